// File: rtl/interrupt_sequencer_if.sv
// Bundles the interrupt request/acknowledge and sequencing signals shared by
// the core (master) and the interrupt sequencer (slave).
interface interrupt_sequencer_if #(
  parameter int NUM_IRQ = 8,
  parameter int PC_W    = 14
);
  logic [NUM_IRQ-1:0] irq_req;
  logic               i_flag;
  logic               instr_boundary;
  logic               reti_exec;
  logic [1:0]         interrupt_stage;
  logic [NUM_IRQ-1:0] irq_ack;
  logic [PC_W-1:0]    vector_addr;
  logic               stall_fetch;
  logic               clear_i;
  logic               set_i;
  logic               in_service;

  modport master (
    output irq_req, i_flag, instr_boundary, reti_exec,
    input  interrupt_stage, irq_ack, vector_addr, stall_fetch, clear_i, set_i, in_service
  );

  modport slave (
    input  irq_req, i_flag, instr_boundary, reti_exec,
    output interrupt_stage, irq_ack, vector_addr, stall_fetch, clear_i, set_i, in_service
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Fixed-priority interrupt arbiter and three-step entry sequencer (push PC high,
// push PC low, load vector) with RETI guard and nesting-depth tracking.
module interrupt_sequencer #(
  parameter int NUM_IRQ = 8,
  parameter int PC_W    = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  interrupt_sequencer_if.slave  sif
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;
  logic [PC_W-1:0]    vector_addr_q, vector_addr_d;
  logic               stall_fetch_q, stall_fetch_d;
  logic               clear_i_q, clear_i_d;
  logic               set_i_q, set_i_d;
  logic               in_service_q, in_service_d;
  logic               guard_q, guard_d;
  logic [3:0]         depth_q, depth_d;

  logic [IDX_W-1:0]   winner;
  logic               take;

  // Vector n lives at word address 2n; index 0 is vector 1.
  function automatic logic [PC_W-1:0] vector_of(input logic [IDX_W-1:0] idx);
    return PC_W'((32'(idx) + 32'd1) << 1);
  endfunction

  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (sif.irq_req[i]) winner = IDX_W'(i);
    end

    // A boundary coinciding with RETI is blocked here; the next one by guard_q.
    take = (state_q == IDLE) && sif.instr_boundary && sif.i_flag &&
           (|sif.irq_req) && !guard_q && !sif.reti_exec;

    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = S1;
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    irq_ack_d = '0;
    if (take) irq_ack_d[winner] = 1'b1;

    vector_addr_d = take ? vector_of(winner) : vector_addr_q;
    clear_i_d     = take;
    stall_fetch_d = (state_d != IDLE);
    set_i_d       = sif.reti_exec;

    guard_d = guard_q;
    if (sif.reti_exec)           guard_d = 1'b1;
    else if (sif.instr_boundary) guard_d = 1'b0;

    depth_d = depth_q;
    if (take && !sif.reti_exec) begin
      if (depth_q != 4'd15) depth_d = depth_q + 4'd1;
    end else if (sif.reti_exec && !take) begin
      if (depth_q != 4'd0) depth_d = depth_q - 4'd1;
    end

    in_service_d = (depth_d != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      irq_ack_q     <= '0;
      vector_addr_q <= '0;
      stall_fetch_q <= 1'b0;
      clear_i_q     <= 1'b0;
      set_i_q       <= 1'b0;
      in_service_q  <= 1'b0;
      guard_q       <= 1'b0;
      depth_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      irq_ack_q     <= irq_ack_d;
      vector_addr_q <= vector_addr_d;
      stall_fetch_q <= stall_fetch_d;
      clear_i_q     <= clear_i_d;
      set_i_q       <= set_i_d;
      in_service_q  <= in_service_d;
      guard_q       <= guard_d;
      depth_q       <= depth_d;
    end
  end

  assign sif.interrupt_stage = state_q;
  assign sif.irq_ack         = irq_ack_q;
  assign sif.vector_addr     = vector_addr_q;
  assign sif.stall_fetch     = stall_fetch_q;
  assign sif.clear_i         = clear_i_q;
  assign sif.set_i           = set_i_q;
  assign sif.in_service      = in_service_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: entry sequence, priority, masking,
// RETI guard, nesting depth, reset abort and mid-sequence input changes.
module tb_interrupt_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  int   total  = 0;
  int   passed = 0;

  interrupt_sequencer_if #(.NUM_IRQ(8), .PC_W(14)) bus ();

  interrupt_sequencer #(.NUM_IRQ(8), .PC_W(14)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [1:0] stage, input logic [7:0] ack,
                         input logic [13:0] vec, input logic stall, input logic clr,
                         input logic seti, input logic insvc);
    chk({tag, ".stage"}, 32'(bus.interrupt_stage), 32'(stage));
    chk({tag, ".ack"},   32'(bus.irq_ack),         32'(ack));
    chk({tag, ".vec"},   32'(bus.vector_addr),     32'(vec));
    chk({tag, ".stall"}, 32'(bus.stall_fetch),     32'(stall));
    chk({tag, ".clr"},   32'(bus.clear_i),         32'(clr));
    chk({tag, ".seti"},  32'(bus.set_i),           32'(seti));
    chk({tag, ".insvc"}, 32'(bus.in_service),      32'(insvc));
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.irq_req        = 8'h00;
    bus.i_flag         = 1'b0;
    bus.instr_boundary = 1'b0;
    bus.reti_exec      = 1'b0;
    tick(); tick();
    chk_out("reset", 2'd0, 8'h00, 14'd0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // Single request, index 2 -> vector address 6
    bus.i_flag = 1'b1; bus.irq_req = 8'h04; bus.instr_boundary = 1'b1;
    tick(); chk_out("single.s1", 2'd1, 8'h04, 14'd6, 1, 1, 0, 1);
    bus.instr_boundary = 1'b0;
    tick(); chk_out("single.s2", 2'd2, 8'h00, 14'd6, 1, 0, 0, 1);
    tick(); chk_out("single.s3", 2'd3, 8'h00, 14'd6, 1, 0, 0, 1);
    tick(); chk_out("single.idle", 2'd0, 8'h00, 14'd6, 0, 0, 0, 1);

    // Priority: 0xA0 -> index 5, vector 12 (depth 2)
    bus.irq_req = 8'hA0; bus.instr_boundary = 1'b1;
    tick(); chk_out("prio.s1", 2'd1, 8'h20, 14'd12, 1, 1, 0, 1);
    bus.instr_boundary = 1'b0;
    tick(); tick(); tick();
    chk_out("prio.idle", 2'd0, 8'h00, 14'd12, 0, 0, 0, 1);

    // Masked by I flag
    bus.i_flag = 1'b0; bus.instr_boundary = 1'b1;
    tick(); chk_out("mask", 2'd0, 8'h00, 14'd12, 0, 0, 0, 1);
    bus.instr_boundary = 1'b0;

    // Mid-sequence input changes (depth 3)
    bus.i_flag = 1'b1; bus.irq_req = 8'h01; bus.instr_boundary = 1'b1;
    tick(); chk_out("mid.s1", 2'd1, 8'h01, 14'd2, 1, 1, 0, 1);
    bus.irq_req = 8'h00;
    tick(); chk_out("mid.s2", 2'd2, 8'h00, 14'd2, 1, 0, 0, 1);
    bus.instr_boundary = 1'b0;
    tick(); chk_out("mid.s3", 2'd3, 8'h00, 14'd2, 1, 0, 0, 1);
    tick(); chk_out("mid.idle", 2'd0, 8'h00, 14'd2, 0, 0, 0, 1);
    tick(); chk_out("mid.noretake", 2'd0, 8'h00, 14'd2, 0, 0, 0, 1);

    // RETI guard: coincident boundary and the next one cannot take
    bus.irq_req = 8'h01; bus.reti_exec = 1'b1; bus.instr_boundary = 1'b1;
    tick(); chk_out("guard.reti", 2'd0, 8'h00, 14'd2, 0, 0, 1, 1);
    bus.reti_exec = 1'b0;
    tick(); chk_out("guard.next", 2'd0, 8'h00, 14'd2, 0, 0, 0, 1);
    tick(); chk_out("guard.take", 2'd1, 8'h01, 14'd2, 1, 1, 0, 1);
    bus.instr_boundary = 1'b0; bus.irq_req = 8'h00;
    tick(); tick(); tick();
    chk_out("guard.idle", 2'd0, 8'h00, 14'd2, 0, 0, 0, 1);

    // Nesting: depth 3 unwinds with three RETIs, fourth floors at zero
    bus.reti_exec = 1'b1;
    tick(); chk_out("nest.r1", 2'd0, 8'h00, 14'd2, 0, 0, 1, 1);
    tick(); chk_out("nest.r2", 2'd0, 8'h00, 14'd2, 0, 0, 1, 1);
    tick(); chk_out("nest.r3", 2'd0, 8'h00, 14'd2, 0, 0, 1, 0);
    tick(); chk_out("nest.r4", 2'd0, 8'h00, 14'd2, 0, 0, 1, 0);
    bus.reti_exec = 1'b0;
    tick(); chk_out("nest.quiet", 2'd0, 8'h00, 14'd2, 0, 0, 0, 0);

    // Reset during S2 aborts the sequence
    bus.irq_req = 8'h08; bus.instr_boundary = 1'b1;
    tick(); chk_out("rst.guardclr", 2'd0, 8'h00, 14'd2, 0, 0, 0, 0);
    tick(); chk_out("rst.s1", 2'd1, 8'h08, 14'd8, 1, 1, 0, 1);
    bus.instr_boundary = 1'b0;
    tick(); chk_out("rst.s2", 2'd2, 8'h00, 14'd8, 1, 0, 0, 1);
    reset_n = 1'b0;
    tick(); chk_out("rst.abort", 2'd0, 8'h00, 14'd0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick(); chk_out("rst.nos3", 2'd0, 8'h00, 14'd0, 0, 0, 0, 0);

    // Depth restarts from zero after reset
    bus.instr_boundary = 1'b1;
    tick(); chk_out("rst.retake", 2'd1, 8'h08, 14'd8, 1, 1, 0, 1);
    bus.instr_boundary = 1'b0; bus.irq_req = 8'h00;
    tick(); tick(); tick();
    bus.reti_exec = 1'b1;
    tick(); chk_out("rst.depth1", 2'd0, 8'h00, 14'd8, 0, 0, 1, 0);
    bus.reti_exec = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
